// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_arbiter_if : pipeline-side fetch/data request bundle for sram_arbiter
// Revision 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_valid;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        stall_if;
  logic        stall_mem;

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  if_data, if_valid, mem_rdata, mem_done, stall_if, stall_mem
  );

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output if_data, if_valid, mem_rdata, mem_done, stall_if, stall_mem
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : shares one 16-bit async SRAM between fetch and data ports
// Revision 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  sram_arbiter_if.slave     pipe,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [15:0]       sram_dout_o,
  input  logic [15:0]       sram_din_i,
  output logic              sram_dout_en_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
      $error("sram_arbiter: WAIT_CYCLES must be in 0..7");
    end
    if (ADDR_W < 16) begin : g_bad_addr
      $error("sram_arbiter: ADDR_W must be at least 16");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_RD    = 3'd1,
    S_MEM_RD   = 3'd2,
    S_WR_SETUP = 3'd3,
    S_WR_PULSE = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_mem_q, owner_mem_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]       sram_dout_q, sram_dout_d;
  logic              dout_en_q, dout_en_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [15:0]       if_data_q, if_data_d;
  logic [15:0]       mem_rdata_q, mem_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              w_last;

  assign w_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    wr_d        = wr_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 3'd0;
        // A simultaneous read+write is resolved as a write by testing it first.
        if (pipe.mem_write) begin
          state_d     = S_WR_SETUP;
          owner_mem_d = 1'b1;
          wr_d        = 1'b1;
          sram_addr_d = ADDR_W'(pipe.mem_addr);
          sram_dout_d = pipe.mem_wdata;
        end else if (pipe.mem_read) begin
          state_d     = S_MEM_RD;
          owner_mem_d = 1'b1;
          wr_d        = 1'b0;
          sram_addr_d = ADDR_W'(pipe.mem_addr);
        end else if (pipe.if_req) begin
          state_d     = S_IF_RD;
          owner_mem_d = 1'b0;
          wr_d        = 1'b0;
          sram_addr_d = ADDR_W'(pipe.if_addr);
        end
      end
      S_IF_RD, S_MEM_RD: begin
        if (w_last) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
          if (owner_mem_q) begin
            mem_rdata_d = sram_din_i;
          end else begin
            if_data_d = sram_din_i;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (w_last) begin
          cnt_d   = 3'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase

    // Strobes are decoded from the next state so the registered pins line up
    // with the state they belong to.
    ce_n_d     = ~((state_d == S_IF_RD) || (state_d == S_MEM_RD) ||
                   (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE));
    oe_n_d     = ~((state_d == S_IF_RD) || (state_d == S_MEM_RD));
    we_n_d     = ~(state_d == S_WR_PULSE);
    dout_en_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
                 ((state_d == S_DONE) && wr_d);
    if_valid_d = (state_d == S_DONE) && !owner_mem_d;
    mem_done_d = (state_d == S_DONE) && owner_mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      owner_mem_q <= 1'b0;
      wr_q        <= 1'b0;
      sram_addr_q <= '0;
      sram_dout_q <= 16'h0000;
      dout_en_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      if_data_q   <= 16'h0000;
      mem_rdata_q <= 16'h0000;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      wr_q        <= wr_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      dout_en_q   <= dout_en_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign sram_addr_o    = sram_addr_q;
  assign sram_dout_o    = sram_dout_q;
  assign sram_dout_en_o = dout_en_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;

  assign pipe.if_data   = if_data_q;
  assign pipe.if_valid  = if_valid_q;
  assign pipe.mem_rdata = mem_rdata_q;
  assign pipe.mem_done  = mem_done_q;
  assign pipe.stall_if  = pipe.if_req & ~if_valid_q;
  assign pipe.stall_mem = (pipe.mem_read | pipe.mem_write) & ~mem_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_arbiter : scoreboard bench for sram_arbiter with WAIT_CYCLES = 1
// Revision 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;
  localparam int ADDR_W      = 18;
  localparam int WAIT_CYCLES = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if pipe ();

  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dout;
  logic [15:0]       sram_din;
  logic              sram_dout_en;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;

  sram_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe           (pipe),
    .sram_addr_o    (sram_addr),
    .sram_dout_o    (sram_dout),
    .sram_din_i     (sram_din),
    .sram_dout_en_o (sram_dout_en),
    .sram_ce_n_o    (ce_n),
    .sram_oe_n_o    (oe_n),
    .sram_we_n_o    (we_n)
  );

  // Behavioural SRAM; a poison value is returned whenever the read path is off.
  logic [15:0] sram_mem [0:(1<<ADDR_W)-1];
  assign sram_din = (!ce_n && !oe_n) ? sram_mem[sram_addr] : 16'hDEAD;
  always @(posedge clk) begin
    if (!ce_n && !we_n && sram_dout_en) sram_mem[sram_addr] <= sram_dout;
  end

  typedef struct packed {
    logic        port;   // 1 = data port, 0 = fetch port
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc;

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic sb_pop(output exp_t e);
    if (sb.size() == 0) e = 'x;
    else e = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pipe.if_req = 1'b1; pipe.mem_read = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (ce_n !== 1'b1) begin n_err++; $display("FAIL rst_ce_n: got %b want 1", ce_n); end
    n_cmp++; if (oe_n !== 1'b1) begin n_err++; $display("FAIL rst_oe_n: got %b want 1", oe_n); end
    n_cmp++; if (we_n !== 1'b1) begin n_err++; $display("FAIL rst_we_n: got %b want 1", we_n); end
    n_cmp++; if (sram_dout_en !== 1'b0) begin n_err++; $display("FAIL rst_dout_en: got %b want 0", sram_dout_en); end
    n_cmp++; if (sram_addr !== 18'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
    n_cmp++; if (sram_dout !== 16'h0) begin n_err++; $display("FAIL rst_dout: got %h want 0", sram_dout); end
    n_cmp++; if (pipe.if_data !== 16'h0) begin n_err++; $display("FAIL rst_if_data: got %h want 0", pipe.if_data); end
    n_cmp++; if (pipe.mem_rdata !== 16'h0) begin n_err++; $display("FAIL rst_mem_rdata: got %h want 0", pipe.mem_rdata); end
    n_cmp++; if (pipe.if_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_valid: got %b want 0", pipe.if_valid); end
    n_cmp++; if (pipe.mem_done !== 1'b0) begin n_err++; $display("FAIL rst_mem_done: got %b want 0", pipe.mem_done); end
    n_cmp++; if (pipe.stall_if !== 1'b1) begin n_err++; $display("FAIL rst_stall_if_hi: got %b want 1", pipe.stall_if); end
    n_cmp++; if (pipe.stall_mem !== 1'b1) begin n_err++; $display("FAIL rst_stall_mem_hi: got %b want 1", pipe.stall_mem); end
    pipe.if_req = 1'b0; pipe.mem_read = 1'b0;
    #1;
    n_cmp++; if (pipe.stall_if !== 1'b0) begin n_err++; $display("FAIL rst_stall_if_lo: got %b want 0", pipe.stall_if); end
    n_cmp++; if (pipe.stall_mem !== 1'b0) begin n_err++; $display("FAIL rst_stall_mem_lo: got %b want 0", pipe.stall_mem); end
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    bit   seen = 0;
    pipe.if_addr = 16'h0004; pipe.if_req = 1'b1;
    sb.push_back(exp_t'{port: 1'b0, data: 16'h6801});
    cyc = 0;
    #1;
    n_cmp++; if (pipe.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", pipe.stall_if); end
    n_cmp++; if (oe_n !== 1'b1) begin n_err++; $display("FAIL fetch_oe_c0: got %b want 1", oe_n); end
    for (int c = 1; c <= 6 && !seen; c++) begin
      step();
      if (cyc <= 3) begin
        n_cmp++; if (oe_n !== ((cyc <= 2) ? 1'b0 : 1'b1)) begin n_err++; $display("FAIL fetch_oe_c%0d: got %b want %b", cyc, oe_n, (cyc <= 2) ? 1'b0 : 1'b1); end
      end
      if (cyc == 1) begin
        n_cmp++; if (sram_addr !== 18'h00004) begin n_err++; $display("FAIL fetch_addr: got %h want 00004", sram_addr); end
      end
      if (pipe.if_valid) begin
        seen = 1;
        sb_pop(e);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL fetch_valid_cycle: got %0d want 3", cyc); end
        n_cmp++; if (pipe.stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_release: got %b want 0", pipe.stall_if); end
        n_cmp++; if (e.port !== 1'b0) begin n_err++; $display("FAIL fetch_sb_port: got %b want 0", e.port); end
        n_cmp++; if (pipe.if_data !== e.data) begin n_err++; $display("FAIL fetch_data: got %h want %h", pipe.if_data, e.data); end
        pipe.if_req = 1'b0;
      end else begin
        n_cmp++; if (pipe.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c%0d: got %b want 1", cyc, pipe.stall_if); end
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL fetch_timeout: got no if_valid want one"); pipe.if_req = 1'b0; end
    step();
    n_cmp++; if (ce_n !== 1'b1) begin n_err++; $display("FAIL fetch_idle_ce: got %b want 1", ce_n); end
  endtask

  task automatic test_store();
    exp_t e;
    bit   seen = 0;
    pipe.mem_addr = 16'h8010; pipe.mem_wdata = 16'hBEEF; pipe.mem_write = 1'b1;
    cyc = 0;
    #1;
    n_cmp++; if (pipe.stall_mem !== 1'b1) begin n_err++; $display("FAIL store_stall_c0: got %b want 1", pipe.stall_mem); end
    for (int c = 1; c <= 8 && !seen; c++) begin
      step();
      if (cyc == 1) begin
        n_cmp++; if ({ce_n, we_n, sram_dout_en} !== 3'b011) begin n_err++; $display("FAIL store_setup_strobes: got ce_n/we_n/en=%b want 011", {ce_n, we_n, sram_dout_en}); end
        n_cmp++; if (sram_addr !== 18'h08010) begin n_err++; $display("FAIL store_addr: got %h want 08010", sram_addr); end
        n_cmp++; if (sram_dout !== 16'hBEEF) begin n_err++; $display("FAIL store_dout: got %h want BEEF", sram_dout); end
      end
      if (cyc == 2 || cyc == 3) begin
        n_cmp++; if ({ce_n, we_n, sram_dout_en} !== 3'b001) begin n_err++; $display("FAIL store_pulse_c%0d: got ce_n/we_n/en=%b want 001", cyc, {ce_n, we_n, sram_dout_en}); end
      end
      if (pipe.mem_done) begin
        seen = 1;
        n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL store_done_cycle: got %0d want 4", cyc); end
        n_cmp++; if ({we_n, sram_dout_en} !== 2'b11) begin n_err++; $display("FAIL store_hold: got we_n/en=%b want 11", {we_n, sram_dout_en}); end
        n_cmp++; if (pipe.stall_mem !== 1'b0) begin n_err++; $display("FAIL store_stall_release: got %b want 0", pipe.stall_mem); end
        pipe.mem_write = 1'b0;
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL store_timeout: got no mem_done want one"); pipe.mem_write = 1'b0; end
    step();
    n_cmp++; if (sram_dout_en !== 1'b0) begin n_err++; $display("FAIL store_idle_en: got %b want 0", sram_dout_en); end
    // Read the stored word back through the data port.
    seen = 0;
    pipe.mem_read = 1'b1;
    sb.push_back(exp_t'{port: 1'b1, data: 16'hBEEF});
    cyc = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      step();
      if (pipe.mem_done) begin
        seen = 1;
        sb_pop(e);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL readback_cycle: got %0d want 3", cyc); end
        n_cmp++; if (e.port !== 1'b1) begin n_err++; $display("FAIL readback_sb_port: got %b want 1", e.port); end
        n_cmp++; if (pipe.mem_rdata !== e.data) begin n_err++; $display("FAIL readback_data: got %h want %h", pipe.mem_rdata, e.data); end
        pipe.mem_read = 1'b0;
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL readback_timeout: got no mem_done want one"); pipe.mem_read = 1'b0; end
    step();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    bit   got_if = 0;
    pipe.if_addr = 16'h0020; pipe.mem_addr = 16'h0100;
    pipe.if_req = 1'b1; pipe.mem_read = 1'b1;
    sb.push_back(exp_t'{port: 1'b1, data: 16'h1111});
    sb.push_back(exp_t'{port: 1'b0, data: 16'h5A5A});
    cyc = 0;
    for (int c = 1; c <= 12 && !got_if; c++) begin
      step();
      if (cyc == 5) begin
        n_cmp++; if ({oe_n, sram_addr} !== {1'b0, 18'h00020}) begin n_err++; $display("FAIL simul_fetch_start: got oe_n=%b addr=%h want 0/00020", oe_n, sram_addr); end
      end
      if (pipe.mem_done) begin
        sb_pop(e);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL simul_mem_cycle: got %0d want 3", cyc); end
        n_cmp++; if (e.port !== 1'b1) begin n_err++; $display("FAIL simul_order_mem: got port %b want 1", e.port); end
        n_cmp++; if (pipe.mem_rdata !== e.data) begin n_err++; $display("FAIL simul_mem_data: got %h want %h", pipe.mem_rdata, e.data); end
        pipe.mem_read = 1'b0;
      end
      if (pipe.if_valid) begin
        got_if = 1;
        sb_pop(e);
        n_cmp++; if (cyc != 7) begin n_err++; $display("FAIL simul_if_cycle: got %0d want 7", cyc); end
        n_cmp++; if (e.port !== 1'b0) begin n_err++; $display("FAIL simul_order_if: got port %b want 0", e.port); end
        n_cmp++; if (pipe.if_data !== e.data) begin n_err++; $display("FAIL simul_if_data: got %h want %h", pipe.if_data, e.data); end
        pipe.if_req = 1'b0;
      end
    end
    n_cmp++; if (!got_if) begin n_err++; $display("FAIL simul_timeout: got no if_valid want one"); end
    pipe.if_req = 1'b0; pipe.mem_read = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit   got_if = 0;
    int   n_done = 0;
    pipe.if_addr = 16'h0004; pipe.mem_addr = 16'h0100;
    pipe.if_req = 1'b1; pipe.mem_read = 1'b1;
    sb.push_back(exp_t'{port: 1'b1, data: 16'h1111});
    sb.push_back(exp_t'{port: 1'b1, data: 16'h2222});
    sb.push_back(exp_t'{port: 1'b0, data: 16'h6801});
    cyc = 0;
    for (int c = 1; c <= 16 && !got_if; c++) begin
      step();
      if (!pipe.if_valid) begin
        n_cmp++; if (pipe.stall_if !== 1'b1) begin n_err++; $display("FAIL b2b_stall_if_c%0d: got %b want 1", cyc, pipe.stall_if); end
      end
      if (pipe.mem_done) begin
        n_done++;
        sb_pop(e);
        n_cmp++; if (cyc != ((n_done == 1) ? 3 : 7)) begin n_err++; $display("FAIL b2b_load%0d_cycle: got %0d want %0d", n_done, cyc, (n_done == 1) ? 3 : 7); end
        n_cmp++; if (e.port !== 1'b1) begin n_err++; $display("FAIL b2b_load%0d_port: got %b want 1", n_done, e.port); end
        n_cmp++; if (pipe.mem_rdata !== e.data) begin n_err++; $display("FAIL b2b_load%0d_data: got %h want %h", n_done, pipe.mem_rdata, e.data); end
        n_cmp++; if (pipe.stall_mem !== 1'b0) begin n_err++; $display("FAIL b2b_stall_mem_release: got %b want 0", pipe.stall_mem); end
        if (n_done == 1) pipe.mem_addr = 16'h0101;
        else pipe.mem_read = 1'b0;
      end
      if (pipe.if_valid) begin
        got_if = 1;
        sb_pop(e);
        n_cmp++; if (cyc != 11) begin n_err++; $display("FAIL b2b_if_cycle: got %0d want 11", cyc); end
        n_cmp++; if (e.port !== 1'b0) begin n_err++; $display("FAIL b2b_if_port: got %b want 0", e.port); end
        n_cmp++; if (pipe.if_data !== e.data) begin n_err++; $display("FAIL b2b_if_data: got %h want %h", pipe.if_data, e.data); end
        pipe.if_req = 1'b0;
      end
    end
    n_cmp++; if (!got_if) begin n_err++; $display("FAIL b2b_timeout: got no if_valid want one"); end
    pipe.if_req = 1'b0; pipe.mem_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen = 0;
    pipe.mem_addr = 16'h0101; pipe.mem_read = 1'b1;
    cyc = 0;
    step();
    n_cmp++; if (oe_n !== 1'b0) begin n_err++; $display("FAIL rmid_oe_active: got %b want 0", oe_n); end
    step();
    rst = 1'b1;
    #1;
    n_cmp++; if ({ce_n, oe_n} !== 2'b11) begin n_err++; $display("FAIL rmid_strobes: got ce_n/oe_n=%b want 11", {ce_n, oe_n}); end
    n_cmp++; if (pipe.mem_done !== 1'b0) begin n_err++; $display("FAIL rmid_done_0: got %b want 0", pipe.mem_done); end
    n_cmp++; if (pipe.mem_rdata !== 16'h0) begin n_err++; $display("FAIL rmid_rdata: got %h want 0", pipe.mem_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (pipe.mem_done !== 1'b0) begin n_err++; $display("FAIL rmid_done_1: got %b want 0", pipe.mem_done); end
    rst = 1'b0;
    sb.push_back(exp_t'{port: 1'b1, data: 16'h2222});
    cyc = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      step();
      if (pipe.mem_done) begin
        seen = 1;
        sb_pop(e);
        n_cmp++; if (cyc != 3) begin n_err++; $display("FAIL rmid_retry_cycle: got %0d want 3", cyc); end
        n_cmp++; if (e.port !== 1'b1) begin n_err++; $display("FAIL rmid_retry_port: got %b want 1", e.port); end
        n_cmp++; if (pipe.mem_rdata !== e.data) begin n_err++; $display("FAIL rmid_retry_data: got %h want %h", pipe.mem_rdata, e.data); end
        pipe.mem_read = 1'b0;
      end
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_timeout: got no mem_done want one"); end
    pipe.mem_read = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sram_mem[18'h00004] = 16'h6801;
    sram_mem[18'h00020] = 16'h5A5A;
    sram_mem[18'h00100] = 16'h1111;
    sram_mem[18'h00101] = 16'h2222;
    pipe.if_req    = 1'b0;
    pipe.if_addr   = 16'h0000;
    pipe.mem_read  = 1'b0;
    pipe.mem_write = 1'b0;
    pipe.mem_addr  = 16'h0000;
    pipe.mem_wdata = 16'h0000;
    cyc = 0;

    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();

    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drained: got %0d entries want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
